isqrt_shared_arbiter: RTL and testbench
=======================================

// Module: isqrt_shared_arbiter
// PURPOSE
//  Shares one pipelined isqrt unit between N_REQ requesters, e.g. formula FSMs that
//  would otherwise each need their own isqrt instance.
//  Grants round-robin and forwards the granted x to the isqrt unit.
//  Tracks in-flight requester IDs in a tag FIFO and routes each isqrt result back
//  to its owner. isqrt returns results strictly in issue order.
// PARAMETERS
//  N_REQ         4   number of requesters, 2..8
//  MAX_INFLIGHT  8   tag FIFO depth = max outstanding isqrt ops; power of 2, >= 2
// PORTS
//  clk            in   1            clock, all logic on rising edge
//  rst_n          in   1            asynchronous reset, active-low
//  req_vld        in   N_REQ        per-requester request valid
//  req_x          in   N_REQ*32     packed args; requester i in [32*i +: 32]
//  req_rdy        out  N_REQ        one-hot accept; transfer when req_vld[i] & req_rdy[i]
//  rsp_vld        out  N_REQ        one-hot result valid, registered
//  rsp_y          out  16           result, shared by all requesters, registered
//  isqrt_x_vld    out  1            to isqrt unit
//  isqrt_x        out  32           to isqrt unit
//  isqrt_y_vld    in   1            from isqrt unit
//  isqrt_y        in   16           from isqrt unit
//  busy           out  1            tag FIFO non-empty, i.e. ops in flight
//  err_orphan     out  1            sticky: isqrt_y_vld seen with tag FIFO empty
// BEHAVIOUR
//  Reset values (async, rst_n=0)
//   - rr_ptr=0, FIFO empty, rsp_vld=0, rsp_y=0, err_orphan=0.
//   - Any in-flight results are discarded.
//  Accept condition
//   - can_issue = !full | isqrt_y_vld. A same-cycle pop frees a slot.
//  Grant (combinational, same cycle)
//   - Winner = first i with req_vld[i], searched from rr_ptr upward and wrapping.
//   - If can_issue: req_rdy[winner]=1, isqrt_x_vld=1, isqrt_x=req_x[winner].
//   - Otherwise all req_rdy=0 and isqrt_x_vld=0. isqrt_x is don't-care when not valid.
//  Requester obligations
//   - Hold req_vld and req_x stable until accepted.
//   - req_vld may drop only after acceptance.
//  Pointer update
//   - On accept: rr_ptr <= winner+1 mod N_REQ.
//   - Otherwise rr_ptr holds.
//  Tag FIFO
//   - Push winner ID on accept.
//   - Pop on isqrt_y_vld.
//   - Push and pop in the same cycle are legal when full or empty+pop.
//   - Count stays unchanged in that case.
//  Response, latency 1 cycle after isqrt_y_vld
//   - rsp_vld <= onehot(head tag); rsp_y <= isqrt_y.
//   - Cycles with no pop: rsp_vld <= 0 and rsp_y holds.
//   - Requesters must always accept a response; there is no back-pressure.
//  Orphan result (isqrt_y_vld with FIFO empty)
//   - No pop, rsp_vld stays 0, err_orphan <= 1 until reset.
//  Reset mid-operation
//   - Returns to reset values.
//   - Isqrt results arriving afterwards are orphans; the system must also reset isqrt.
//  Throughput
//   - 1 issue/cycle while ops are in flight.
//   - One requester streaming can be granted every cycle only when it is the sole requester.
// CONFIGURATION
//  Macro ISQRT_ARB_STATS_EN
//   - Defined: adds output stall_cnt [31:0] and output grant_cnt [N_REQ*32].
//     - stall_cnt increments each cycle with |req_vld & !can_issue.
//     - grant_cnt[i] increments on each accept of requester i.
//     - Both reset to 0 and wrap silently.
//   - Undefined: these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package isqrt_arb_pkg
//   - typedefs: isqrt_arg_t (logic [31:0]), isqrt_res_t (logic [15:0]).
//   - localparam function tag_w(n) = $clog2(n) (min 1).
//  Sub-module isqrt_arb_tag_fifo
//   - Synchronous FIFO: DEPTH, WIDTH.
//   - Interface: push/pop/head/full/empty/count; async active-low reset.
//  Top module: RR grant logic, issue mux, response demux and register, optional counters.
// TESTING
//  Bench isqrt model: fixed latency 4, 1 op/cycle, in-order.
//  1. Only req 2 is valid, x=144, for one beat.
//     -> rdy[2] in the same cycle; rsp_vld=4'b0100, rsp_y=12 exactly 5 cycles later.
//  2. All 4 valid continuously, x_i = i*i+0x100 per beat.
//     -> grants 0,1,2,3,0,... one per cycle; each rsp_vld one-hot matches issue order.
//  3. Set MAX_INFLIGHT=2 and hold isqrt latency >2.
//     -> after 2 issues req_rdy=0; a new issue occurs in the same cycle as the first isqrt_y_vld.
//  4. Pulse isqrt_y_vld with y=7 while idle.
//     -> err_orphan=1 next cycle and stays 1; rsp_vld stays 0.
//  5. Drive rst_n=0 with 3 ops in flight.
//     -> immediately rsp_vld=0, busy=0, rr_ptr=0; the next lone request from req 1 is granted.
//  6. Stats build, scenario 2 for 8 accepts.
//     -> grant_cnt=2 each; stall_cnt=0.

Source files
------------

// File: rtl/isqrt_arb_pkg.sv
// Shared types and helpers for the isqrt arbiter slice.
// Optional statistics counters are enabled with ISQRT_ARB_STATS_EN.
package isqrt_arb_pkg;

  typedef logic [31:0] isqrt_arg_t;
  typedef logic [15:0] isqrt_res_t;

  // Width of a requester ID, never narrower than one bit.
  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/isqrt_arb_tag_fifo.sv
// Tag FIFO remembering which requester owns each in-flight isqrt operation.
// DEPTH must be a power of two so the pointers wrap naturally.
module isqrt_arb_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/isqrt_shared_arbiter.sv
// Round-robin sharing of one in-order pipelined isqrt unit between N_REQ requesters.
// Define ISQRT_ARB_STATS_EN to add the stall_cnt / grant_cnt statistics outputs.
module isqrt_shared_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_vld,
  input  logic [N_REQ*32-1:0]  req_x,
  output logic [N_REQ-1:0]     req_rdy,
  output logic [N_REQ-1:0]     rsp_vld,
  output isqrt_res_t           rsp_y,
  output logic                 isqrt_x_vld,
  output isqrt_arg_t           isqrt_x,
  input  logic                 isqrt_y_vld,
  input  isqrt_res_t           isqrt_y,
  output logic                 busy,
  output logic                 err_orphan
`ifdef ISQRT_ARB_STATS_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [N_REQ*32-1:0]  grant_cnt
`endif
);

  localparam int TW = tag_w(N_REQ);
  localparam int FW = $clog2(MAX_INFLIGHT) + 1;

  logic [TW-1:0] rr_ptr;
  logic [TW-1:0] winner;
  logic [TW-1:0] head_tag;
  logic [FW-1:0] fifo_count;
  logic          found;
  logic          can_issue;
  logic          accept;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;

  function automatic logic [TW-1:0] rr_idx(input logic [TW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return TW'(s);
  endfunction

  // Walk from the farthest offset down so the closest valid requester to rr_ptr wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_vld[rr_idx(rr_ptr, k)]) begin
        winner = rr_idx(rr_ptr, k);
        found  = 1'b1;
      end
    end
  end

  assign can_issue   = !fifo_full || isqrt_y_vld;
  assign accept      = found && can_issue;
  assign pop         = isqrt_y_vld && !fifo_empty;
  assign req_rdy     = accept ? (N_REQ'(1) << winner) : '0;
  assign isqrt_x_vld = accept;
  assign isqrt_x     = req_x[32*winner +: 32];
  assign busy        = (fifo_count != '0);

  isqrt_arb_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (TW)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .din   (winner),
    .pop   (pop),
    .head  (head_tag),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      rsp_vld    <= '0;
      rsp_y      <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (accept) rr_ptr <= (winner == TW'(N_REQ - 1)) ? '0 : winner + TW'(1);
      rsp_vld <= pop ? (N_REQ'(1) << head_tag) : '0;
      if (pop) rsp_y <= isqrt_y;
      if (isqrt_y_vld && fifo_empty) err_orphan <= 1'b1;
    end
  end

`ifdef ISQRT_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      grant_cnt <= '0;
    end else begin
      if (|req_vld && !can_issue) stall_cnt <= stall_cnt + 32'd1;
      for (int i = 0; i < N_REQ; i++) begin
        if (accept && winner == TW'(i)) grant_cnt[32*i +: 32] <= grant_cnt[32*i +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_isqrt_shared_arbiter.sv
// Randomized self-checking bench for isqrt_shared_arbiter against a queue-based model.
// Compile with ISQRT_ARB_STATS_EN to also check the statistics counters.
module tb_isqrt_shared_arbiter;

  localparam int NR         = 4;
  localparam int MAIN_DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;

  logic [NR-1:0]    req_vld = '0;
  logic [NR*32-1:0] req_x = '0;
  logic [NR-1:0]    req_rdy;
  logic [NR-1:0]    rsp_vld;
  logic [15:0]      rsp_y;
  logic             isqrt_x_vld;
  logic [31:0]      isqrt_x;
  logic             isqrt_y_vld = 1'b0;
  logic [15:0]      isqrt_y = '0;
  logic             busy;
  logic             err_orphan;

  logic [NR-1:0]    s_req_vld = '0;
  logic [NR*32-1:0] s_req_x = '0;
  logic [NR-1:0]    s_req_rdy;
  logic [NR-1:0]    s_rsp_vld;
  logic [15:0]      s_rsp_y;
  logic             s_isqrt_x_vld;
  logic [31:0]      s_isqrt_x;
  logic             s_isqrt_y_vld = 1'b0;
  logic [15:0]      s_isqrt_y = '0;
  logic             s_busy;
  logic             s_err_orphan;

`ifdef ISQRT_ARB_STATS_EN
  logic [31:0]      stall_cnt;
  logic [NR*32-1:0] grant_cnt;
  logic [31:0]      s_stall_cnt;
  logic [NR*32-1:0] s_grant_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  isqrt_shared_arbiter #(.N_REQ(NR), .MAX_INFLIGHT(MAIN_DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_vld     (req_vld),
    .req_x       (req_x),
    .req_rdy     (req_rdy),
    .rsp_vld     (rsp_vld),
    .rsp_y       (rsp_y),
    .isqrt_x_vld (isqrt_x_vld),
    .isqrt_x     (isqrt_x),
    .isqrt_y_vld (isqrt_y_vld),
    .isqrt_y     (isqrt_y),
    .busy        (busy),
    .err_orphan  (err_orphan)
`ifdef ISQRT_ARB_STATS_EN
    ,
    .stall_cnt   (stall_cnt),
    .grant_cnt   (grant_cnt)
`endif
  );

  isqrt_shared_arbiter #(.N_REQ(NR), .MAX_INFLIGHT(2)) dut_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_vld     (s_req_vld),
    .req_x       (s_req_x),
    .req_rdy     (s_req_rdy),
    .rsp_vld     (s_rsp_vld),
    .rsp_y       (s_rsp_y),
    .isqrt_x_vld (s_isqrt_x_vld),
    .isqrt_x     (s_isqrt_x),
    .isqrt_y_vld (s_isqrt_y_vld),
    .isqrt_y     (s_isqrt_y),
    .busy        (s_busy),
    .err_orphan  (s_err_orphan)
`ifdef ISQRT_ARB_STATS_EN
    ,
    .stall_cnt   (s_stall_cnt),
    .grant_cnt   (s_grant_cnt)
`endif
  );

  // Reference model state: outstanding ops in issue order, requester intents, isqrt pipe.
  int          rr_m = 0;
  int          q_id[$];
  logic [31:0] q_x[$];
  bit          pending[NR];
  logic [31:0] px[NR];
  bit          refill = 0;
  bit          rand_on = 0;
  int          rate = 50;
  logic [NR-1:0] exp_rsp_vld = '0;
  logic [15:0] exp_rsp_y = '0;
  bit          exp_err = 0;
  bit          st_vld[1:4];
  logic [31:0] st_x[1:4];
  bit          iss_vld = 0;
  logic [31:0] iss_x = '0;

  function automatic logic [15:0] isqrt_ref(input logic [31:0] x);
    longint lo, hi, mid;
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(x)) lo = mid;
      else hi = mid - 1;
    end
    return lo[15:0];
  endfunction

  function automatic logic [31:0] randArg();
    logic [31:0] k;
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 300);
      1: return $urandom;
      2: return 32'hFFFF_FFFF;
      default: begin
        k = $urandom_range(0, 65535);
        return k * k;
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic resetModel();
    rr_m = 0;
    q_id.delete();
    q_x.delete();
    exp_rsp_vld = '0;
    exp_rsp_y = '0;
    exp_err = 0;
    iss_vld = 0;
    iss_x = '0;
    for (int k = 1; k <= 4; k++) begin
      st_vld[k] = 0;
      st_x[k] = '0;
    end
    for (int i = 0; i < NR; i++) begin
      pending[i] = 0;
      px[i] = '0;
    end
  endtask

  // One cycle on the main instance, entered and left at a falling edge.
  task automatic applyStimulus(input bit inj_y);
    int win;
    bit fnd, can, acc;
    checkOutput("rsp_vld", rsp_vld, exp_rsp_vld);
    checkOutput("rsp_y", rsp_y, exp_rsp_y);
    checkOutput("err_orphan", err_orphan, exp_err);
    checkOutput("busy", busy, q_id.size() != 0);
    for (int k = 4; k > 1; k--) begin
      st_vld[k] = st_vld[k-1];
      st_x[k] = st_x[k-1];
    end
    st_vld[1] = iss_vld;
    st_x[1] = iss_x;
    isqrt_y_vld = st_vld[4] | inj_y;
    isqrt_y = inj_y ? 16'd7 : isqrt_ref(st_x[4]);
    if (rand_on) begin
      for (int i = 0; i < NR; i++) begin
        if (!pending[i] && $urandom_range(0, 99) < rate) begin
          pending[i] = 1;
          px[i] = randArg();
        end
      end
    end
    for (int i = 0; i < NR; i++) begin
      req_vld[i] = pending[i];
      req_x[32*i +: 32] = px[i];
    end
    #1;
    fnd = 0;
    win = 0;
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (rr_m + k) % NR;
      if (!fnd && pending[j]) begin
        fnd = 1;
        win = j;
      end
    end
    can = (q_id.size() < MAIN_DEPTH) || isqrt_y_vld;
    acc = fnd && can;
    checkOutput("req_rdy", req_rdy, acc ? (4'b0001 << win) : 4'b0000);
    checkOutput("isqrt_x_vld", isqrt_x_vld, acc);
    if (acc) checkOutput("isqrt_x", isqrt_x, px[win]);
    iss_vld = isqrt_x_vld;
    iss_x = isqrt_x;
    exp_rsp_vld = '0;
    if (isqrt_y_vld) begin
      if (q_id.size() > 0) begin
        exp_rsp_vld = 4'b0001 << q_id.pop_front();
        exp_rsp_y = isqrt_ref(q_x.pop_front());
      end else begin
        exp_err = 1;
      end
    end
    if (acc) begin
      q_id.push_back(win);
      q_x.push_back(px[win]);
      rr_m = (win + 1) % NR;
      pending[win] = 0;
      if (refill) begin
        pending[win] = 1;
        px[win] = win * win + 32'h100;
      end
    end
    @(negedge clk);
  endtask

  // Depth-2 instance, all requesters streaming, isqrt latency 4.
  task automatic runSmallScenario();
    bit          sv[1:4];
    logic [31:0] sx[1:4];
    bit          pv;
    logic [31:0] pxs;
    int          n_iss;
    bit          exp_iss;
    pv = 0;
    pxs = '0;
    n_iss = 0;
    for (int k = 1; k <= 4; k++) begin
      sv[k] = 0;
      sx[k] = '0;
    end
    s_req_vld = 4'hF;
    for (int i = 0; i < NR; i++) s_req_x[32*i +: 32] = 32'd100 * (i + 1);
    for (int t = 0; t < 12; t++) begin
      checkOutput("small_busy", s_busy, t != 0);
      for (int k = 4; k > 1; k--) begin
        sv[k] = sv[k-1];
        sx[k] = sx[k-1];
      end
      sv[1] = pv;
      sx[1] = pxs;
      s_isqrt_y_vld = sv[4];
      s_isqrt_y = isqrt_ref(sx[4]);
      #1;
      exp_iss = (t % 4) < 2;
      checkOutput("small_rdy", s_req_rdy, exp_iss ? (4'b0001 << (n_iss % 4)) : 4'b0000);
      checkOutput("small_x_vld", s_isqrt_x_vld, exp_iss);
      if (exp_iss) n_iss++;
      pv = s_isqrt_x_vld;
      pxs = s_isqrt_x;
      @(negedge clk);
    end
    s_req_vld = '0;
    s_isqrt_y_vld = 1'b0;
`ifdef ISQRT_ARB_STATS_EN
    checkOutput("small_stall_cnt", s_stall_cnt, 6);
    checkOutput("small_grant_cnt0", s_grant_cnt[31:0], 2);
    checkOutput("small_grant_cnt1", s_grant_cnt[63:32], 2);
    checkOutput("small_grant_cnt2", s_grant_cnt[95:64], 1);
    checkOutput("small_grant_cnt3", s_grant_cnt[127:96], 1);
`endif
  endtask

  initial begin
    resetModel();
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_rsp_vld", rsp_vld, 0);
    checkOutput("reset_rsp_y", rsp_y, 0);
    checkOutput("reset_err", err_orphan, 0);
    checkOutput("reset_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] all four requesters streaming");
    refill = 1;
    for (int i = 0; i < NR; i++) begin
      pending[i] = 1;
      px[i] = i * i + 32'h100;
    end
    for (int n = 0; n < 8; n++) applyStimulus(0);
`ifdef ISQRT_ARB_STATS_EN
    for (int i = 0; i < NR; i++) checkOutput("grant_cnt", grant_cnt[32*i +: 32], 2);
    checkOutput("stall_cnt", stall_cnt, 0);
`endif
    for (int n = 0; n < 12; n++) applyStimulus(0);
    refill = 0;
    for (int i = 0; i < NR; i++) pending[i] = 0;
    for (int n = 0; n < 8; n++) applyStimulus(0);

    $display("[TB] lone request from requester 2");
    pending[2] = 1;
    px[2] = 32'd144;
    for (int n = 0; n < 8; n++) applyStimulus(0);

    $display("[TB] orphan result while idle");
    applyStimulus(1);
    for (int n = 0; n < 4; n++) applyStimulus(0);

    $display("[TB] reset with three ops in flight");
    for (int i = 0; i < 3; i++) begin
      pending[i] = 1;
      px[i] = 32'd1000 + i;
      applyStimulus(0);
    end
    rst_n = 1'b0;
    isqrt_y_vld = 1'b0;
    req_vld = '0;
    #1;
    checkOutput("midreset_rsp_vld", rsp_vld, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_err", err_orphan, 0);
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
    pending[1] = 1;
    px[1] = 32'd49;
    pending[3] = 1;
    px[3] = 32'd81;
    applyStimulus(0);
    for (int n = 0; n < 8; n++) applyStimulus(0);

    $display("[TB] randomized traffic");
    rand_on = 1;
    for (int phase = 0; phase < 3; phase++) begin
      rate = (phase == 0) ? 10 : (phase == 1) ? 50 : 90;
      for (int n = 0; n < 150; n++) applyStimulus(0);
    end
    rand_on = 0;
    for (int n = 0; n < 12; n++) applyStimulus(0);
    for (int i = 0; i < NR; i++) pending[i] = 0;
    for (int n = 0; n < 8; n++) applyStimulus(0);

    $display("[TB] two-deep FIFO back-pressure");
    runSmallScenario();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
